sram_banked_wrapper: RTL and testbench

- Parametrised successor to the single-macro 1RW SRAM wrapper.
- Tiles DEPTH_BANKS x WIDTH_COLS instances of SRAM1RW128x8 into one wide, deep 1RW memory.
- Adds a per-byte write mask, a fully registered request stage with a 2-cycle read pipeline and read-valid strobe, and a post-reset zero-initialisation FSM with a ready handshake.
- Sits between RTL clients and the hard SRAM macros in the SRAM experiment designs.

---
 rtl/sram_banked_wrapper.sv | 180 ++++++++++++++++++
 tb/tb_sram_banked_wrapper.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_banked_wrapper.sv
// Banked 1RW memory built from SRAM1RW128x8 macros, with per-byte write mask,
// a registered request stage, 2-cycle read pipeline and post-reset zero fill.

module SRAM1RW128x8 (
  input  logic [6:0] A,
  input  logic       CE,
  input  logic       WEB,
  input  logic       OEB,
  input  logic       CSB,
  input  logic [7:0] I,
  output logic [7:0] O
);

  logic [7:0] mem [128];

  // O is latched at the access edge and held until the next read.
  always_ff @(posedge CE) begin
    if (!CSB && !WEB) begin
      mem[A] <= I;
    end
    if (!CSB && WEB && !OEB) begin
      O <= mem[A];
    end
  end

endmodule

module sram_banked_wrapper #(
  parameter int unsigned MACRO_ADDR_W  = 7,
  parameter int unsigned MACRO_DATA_W  = 8,
  parameter int unsigned DEPTH_BANKS   = 2,
  parameter int unsigned WIDTH_COLS    = 4,
  parameter int unsigned INIT_ON_RESET = 1,
  parameter int unsigned ADDR_W        = MACRO_ADDR_W + $clog2(DEPTH_BANKS),
  parameter int unsigned DATA_W        = MACRO_DATA_W * WIDTH_COLS
) (
  input  logic                  RW0_clk,
  input  logic                  RW0_rst,
  input  logic [ADDR_W-1:0]     RW0_addr,
  input  logic [DATA_W-1:0]     RW0_wdata,
  input  logic [WIDTH_COLS-1:0] RW0_wmask,
  input  logic                  RW0_en,
  input  logic                  RW0_wmode,
  output logic                  RW0_ready,
  output logic [DATA_W-1:0]     RW0_rdata,
  output logic                  RW0_rvalid
);

  localparam int unsigned BANK_W = (DEPTH_BANKS > 1) ? $clog2(DEPTH_BANKS) : 1;
  localparam logic [MACRO_ADDR_W-1:0] INIT_LAST = '1;

  typedef enum logic [1:0] {StIdle, StInit, StRun} state_e;

  state_e                  state_q;
  logic [MACRO_ADDR_W-1:0] init_cnt_q;

  logic                    s1_valid_q;
  logic                    s1_wmode_q;
  logic [ADDR_W-1:0]       s1_addr_q;
  logic [DATA_W-1:0]       s1_wdata_q;
  logic [WIDTH_COLS-1:0]   s1_wmask_q;
  logic [BANK_W-1:0]       s1_bank;

  logic                    p2_valid_q;
  logic [BANK_W-1:0]       p2_bank_q;

  logic                    rvalid_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    accept;

  logic [MACRO_ADDR_W-1:0]                                 m_a;
  logic [WIDTH_COLS-1:0][MACRO_DATA_W-1:0]                 m_i;
  logic [DEPTH_BANKS-1:0][WIDTH_COLS-1:0]                  m_csb;
  logic [DEPTH_BANKS-1:0][WIDTH_COLS-1:0]                  m_web;
  logic [DEPTH_BANKS-1:0][WIDTH_COLS-1:0]                  m_oeb;
  logic [DEPTH_BANKS-1:0][WIDTH_COLS-1:0][MACRO_DATA_W-1:0] m_o;

  generate
    if (DEPTH_BANKS > 1) begin : g_bank_sel
      assign s1_bank = s1_addr_q[ADDR_W-1 -: BANK_W];
    end else begin : g_no_bank_sel
      assign s1_bank = '0;
    end
  endgenerate

  assign RW0_ready  = (state_q == StRun);
  assign RW0_rdata  = rdata_q;
  assign RW0_rvalid = rvalid_q;
  assign accept     = RW0_en & RW0_ready;

  // Macros are driven straight from S1 so the access lands on the following edge.
  always_comb begin
    m_a   = s1_addr_q[MACRO_ADDR_W-1:0];
    m_i   = s1_wdata_q;
    m_csb = '1;
    m_web = '1;
    m_oeb = '1;
    if (RW0_rst) begin
      m_csb = '1;
    end else if (state_q == StInit) begin
      m_a   = init_cnt_q;
      m_i   = '0;
      m_csb = '0;
      m_web = '0;
    end else if (s1_valid_q) begin
      for (int b = 0; b < int'(DEPTH_BANKS); b++) begin
        if (s1_bank == BANK_W'(b)) begin
          for (int c = 0; c < int'(WIDTH_COLS); c++) begin
            m_csb[b][c] = 1'b0;
            m_web[b][c] = s1_wmode_q ? ~s1_wmask_q[c] : 1'b1;
            m_oeb[b][c] = s1_wmode_q;
          end
        end
      end
    end
  end

  generate
    for (genvar b = 0; b < int'(DEPTH_BANKS); b++) begin : g_bank
      for (genvar c = 0; c < int'(WIDTH_COLS); c++) begin : g_col
        SRAM1RW128x8 u_macro (
          .A   (m_a),
          .CE  (RW0_clk),
          .WEB (m_web[b][c]),
          .OEB (m_oeb[b][c]),
          .CSB (m_csb[b][c]),
          .I   (m_i[c]),
          .O   (m_o[b][c])
        );
      end
    end
  endgenerate

  always_ff @(posedge RW0_clk) begin
    if (RW0_rst) begin
      state_q    <= (INIT_ON_RESET != 0) ? StInit : StIdle;
      init_cnt_q <= '0;
      s1_valid_q <= 1'b0;
      s1_wmode_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_wdata_q <= '0;
      s1_wmask_q <= '0;
      p2_valid_q <= 1'b0;
      p2_bank_q  <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      case (state_q)
        StIdle: state_q <= StRun;
        StInit: begin
          // Counter parks at its last value; it never feeds RUN traffic.
          if (init_cnt_q == INIT_LAST) begin
            state_q <= StRun;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        StRun:   state_q <= StRun;
        default: state_q <= StIdle;
      endcase

      s1_valid_q <= accept;
      if (accept) begin
        s1_wmode_q <= RW0_wmode;
        s1_addr_q  <= RW0_addr;
        s1_wdata_q <= RW0_wdata;
        s1_wmask_q <= RW0_wmask;
      end

      p2_valid_q <= s1_valid_q & ~s1_wmode_q;
      p2_bank_q  <= s1_bank;

      rvalid_q <= p2_valid_q;
      if (p2_valid_q) begin
        rdata_q <= m_o[p2_bank_q];
      end
    end
  end

endmodule

// File: tb/tb_sram_banked_wrapper.sv
// Self-checking bench for sram_banked_wrapper: vector table, random traffic
// against a reference memory, and reset/INIT corner sequences.

module tb_sram_banked_wrapper;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        en;
  logic        wmode;
  logic        ready;
  logic [31:0] rdata;
  logic        rvalid;

  sram_banked_wrapper dut (
    .RW0_clk    (clk),
    .RW0_rst    (rst),
    .RW0_addr   (addr),
    .RW0_wdata  (wdata),
    .RW0_wmask  (wmask),
    .RW0_en     (en),
    .RW0_wmode  (wmode),
    .RW0_ready  (ready),
    .RW0_rdata  (rdata),
    .RW0_rvalid (rvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic        wm;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp;
    bit          csb_chk;
  } vec_t;

  exp_t        sbq[$];
  vec_t        vecs[13];
  logic [31:0] model_mem[256];
  logic [31:0] last_rdata;
  int          cyc;
  int          n_cmp;
  int          n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic rst_s;
    exp_t e;
    rst_s = rst;
    @(posedge clk);
    cyc++;
    #1;
    if (rst_s) begin
      last_rdata = '0;
    end
    if (rvalid === 1'b1) begin
      if (sbq.size() == 0) begin
        check("unexpected rvalid", {31'd0, rvalid}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("read data", rdata, e.data);
        check("read latency cycle", cyc, e.due);
      end
      last_rdata = rdata;
    end else begin
      if (sbq.size() != 0 && sbq[0].due <= cyc) begin
        e = sbq.pop_front();
        check("missing rvalid", {31'd0, rvalid}, 32'd1);
      end
      check("rdata hold", rdata, last_rdata);
    end
  endtask

  task automatic issue(input logic wm, input logic [7:0] a, input logic [31:0] wd,
                       input logic [3:0] m, input logic [31:0] exp);
    exp_t e;
    check("ready at issue", {31'd0, ready}, 32'd1);
    en = 1'b1; wmode = wm; addr = a; wdata = wd; wmask = m;
    if (wm) begin
      for (int c = 0; c < 4; c++) begin
        if (m[c]) model_mem[a][c*8 +: 8] = wd[c*8 +: 8];
      end
    end else begin
      e.data = exp;
      e.due  = cyc + 3;
      sbq.push_back(e);
    end
    tick();
  endtask

  task automatic idle(input int n);
    en = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_ready(input bool_drop_dummy, input bit drop_test);
  endtask

  task automatic wait_init(input bit drop_test);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 400) begin
      if (drop_test && n < 5) begin
        en = 1'b1; wmode = 1'b1; addr = 8'h33; wdata = 32'hFFFF_FFFF; wmask = 4'hF;
      end else begin
        en = 1'b0;
      end
      tick();
      n++;
    end
    en = 1'b0;
    check("init ready cycles", n, 128);
  endtask

  initial begin
    logic        wm;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  m;

    cyc = 0; n_cmp = 0; n_fail = 0; last_rdata = '0;
    rst = 1'b1; en = 1'b0; wmode = 1'b0; addr = '0; wdata = '0; wmask = '0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;

    vecs[0]  = '{1'b1, 8'h05, 32'hDEAD_BEEF, 4'b1111, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 8'h05, 32'h0,         4'b0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 8'h05, 32'h1122_3344, 4'b0101, 32'h0,         1'b0};
    vecs[3]  = '{1'b0, 8'h05, 32'h0,         4'b0000, 32'hDE22_BE44, 1'b0};
    vecs[4]  = '{1'b1, 8'h10, 32'hAAAA_AAAA, 4'b1111, 32'h0,         1'b0};
    vecs[5]  = '{1'b1, 8'h90, 32'h5555_5555, 4'b1111, 32'h0,         1'b0};
    vecs[6]  = '{1'b0, 8'h10, 32'h0,         4'b0000, 32'hAAAA_AAAA, 1'b0};
    vecs[7]  = '{1'b0, 8'h90, 32'h0,         4'b0000, 32'h5555_5555, 1'b1};
    vecs[8]  = '{1'b0, 8'h10, 32'h0,         4'b0000, 32'hAAAA_AAAA, 1'b0};
    vecs[9]  = '{1'b1, 8'h20, 32'h1234_5678, 4'b0000, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 8'h20, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{1'b0, 8'hFF, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 32'h0,         4'b0000, 32'h0000_0000, 1'b0};

    // Reset for two edges, then zero fill with a dropped write attempt.
    tick();
    tick();
    check("reset ready", {31'd0, ready}, 32'd0);
    check("reset rvalid", {31'd0, rvalid}, 32'd0);
    check("reset rdata", rdata, 32'd0);
    rst = 1'b0;
    wait_init(1'b1);
    issue(1'b0, 8'h33, '0, '0, 32'h0);
    idle(3);

    for (int i = 0; i < 13; i++) begin
      issue(vecs[i].wm, vecs[i].addr, vecs[i].wdata, vecs[i].mask, vecs[i].exp);
      if (vecs[i].csb_chk) begin
        check("bank0 csb idle", 32'(dut.m_csb[0]), 32'hF);
        check("bank1 csb active", 32'(dut.m_csb[1]), 32'h0);
      end
    end
    idle(4);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        idle(1);
      end else begin
        wm = 1'($urandom_range(1));
        a  = 8'($urandom_range(255) & 32'h8F);
        wd = $urandom;
        m  = 4'($urandom_range(15));
        issue(wm, a, wd, m, model_mem[a]);
      end
    end
    idle(4);

    // Reset lands on the edge after a read is accepted: the read must vanish.
    check("pre-reset ready", {31'd0, ready}, 32'd1);
    en = 1'b1; wmode = 1'b0; addr = 8'h05;
    tick();
    en = 1'b0;
    rst = 1'b1;
    tick();
    check("midreset rvalid", {31'd0, rvalid}, 32'd0);
    check("midreset rdata", rdata, 32'd0);
    check("midreset ready", {31'd0, ready}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    wait_init(1'b0);
    issue(1'b0, 8'h05, '0, '0, 32'h0);
    idle(4);
    check("scoreboard drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
